// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: FSM states, NOP encoding, opcodes and reset PC.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_EXEC = 2'b10,
        S_HALT = 2'b11
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection: sequential (PC+4) or branch target (PC+ImmExt).
module next_pc_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic            pc_src,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    logic [XLEN-1:0] target_s;

    assign pc_plus4 = pc + XLEN'(4);
    assign target_s = pc + imm_ext;

    // Select the successor address; arithmetic wraps modulo 2^XLEN.
    always_comb begin
        next_pc = pc_plus4;
        if (pc_src) begin
            next_pc = target_s;
        end else begin
            next_pc = pc_plus4;
        end
        misalign = is_misaligned(next_pc[1:0]);
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ack port, holds the instruction for the core.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    output logic            fetch_fault,
    output logic [31:0]     instret
);

    fetch_state_t    state_r;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     instr_r;
    logic            req_r;
    logic            valid_r;
    logic            fault_r;
    logic [31:0]     instret_r;

    logic [XLEN-1:0] next_s;
    logic            misalign_s;

    next_pc_gen #(.XLEN(XLEN)) u_next_pc_gen (
        .pc       (pc_r),
        .imm_ext  (ImmExt),
        .pc_src   (PCSrc),
        .pc_plus4 (PCPlus4),
        .next_pc  (next_s),
        .misalign (misalign_s)
    );

    // Fetch FSM with PC, instruction, status and retire-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            pc_r      <= RESET_PC;
            instr_r   <= INSTR_NOP;
            req_r     <= 1'b0;
            valid_r   <= 1'b0;
            fault_r   <= 1'b0;
            instret_r <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= S_REQ;
                    req_r   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        instr_r <= imem_rdata;
                        req_r   <= 1'b0;
                        valid_r <= 1'b1;
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // PCSrc/ImmExt only matter on the retire edge.
                    if (!stall) begin
                        instret_r <= instret_r + 32'd1;
                        valid_r   <= 1'b0;
                        if (misalign_s) begin
                            fault_r <= 1'b1;
                            state_r <= S_HALT;
                        end else begin
                            pc_r    <= next_s;
                            req_r   <= 1'b1;
                            state_r <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
                default: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    state_r <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign Instr       = instr_r;
    assign PC          = pc_r;
    assign instr_valid = valid_r;
    assign fetch_fault = fault_r;
    assign instret     = instret_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized fetch/retire traffic.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        fetch_fault;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    // Transaction-level reference state: where the core should be fetching and how much it retired.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_instret;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .ImmExt      (ImmExt),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction fetch: request must stay stable through `delay` idle cycles, then capture.
    task automatic fetch(input int delay, input logic [31:0] word);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            PCSrc      = 1'($urandom);
            ImmExt     = $urandom;
            stall      = 1'($urandom);
            tick();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        stall      = 1'b1;
        m_instr    = word;
        chk("cap_valid", {31'd0, instr_valid}, 32'd1);
        chk("cap_instr", Instr, m_instr);
        chk("cap_pc", PC, m_pc);
        chk("cap_pcplus4", PCPlus4, m_pc + 32'd4);
        chk("cap_req", {31'd0, imem_req}, 32'd0);
        chk("cap_instret", instret, m_instret);
    endtask

    // Hold for `stalls` cycles, then retire with the given branch decision.
    task automatic retire(input int stalls, input logic src, input logic [31:0] imm, output bit halted);
        logic [31:0] nxt;
        for (int i = 0; i < stalls; i++) begin
            stall   = 1'b1;
            PCSrc   = 1'($urandom);
            ImmExt  = $urandom;
            imem_ack = 1'($urandom);
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", Instr, m_instr);
            chk("stall_pc", PC, m_pc);
            chk("stall_instret", instret, m_instret);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
        PCSrc    = src;
        ImmExt   = imm;
        tick();
        stall  = 1'b1;
        PCSrc  = 1'($urandom);
        ImmExt = $urandom;
        m_instret = m_instret + 32'd1;
        nxt = src ? (m_pc + imm) : (m_pc + 32'd4);
        chk("ret_instret", instret, m_instret);
        chk("ret_valid", {31'd0, instr_valid}, 32'd0);
        if (nxt[1:0] != 2'b00) begin
            halted = 1'b1;
            chk("ret_fault", {31'd0, fetch_fault}, 32'd1);
            chk("ret_req_halt", {31'd0, imem_req}, 32'd0);
            chk("ret_pc_halt", PC, m_pc);
        end else begin
            halted = 1'b0;
            m_pc   = nxt;
            chk("ret_fault", {31'd0, fetch_fault}, 32'd0);
            chk("ret_req", {31'd0, imem_req}, 32'd1);
            chk("ret_addr", imem_addr, m_pc);
        end
    endtask

    initial begin
        bit          h;
        logic [31:0] imm;
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        stall      = 1'b0;
        PCSrc      = 1'b0;
        ImmExt     = 32'd0;
        m_pc       = 32'd0;
        m_instret  = 32'd0;
        m_instr    = 32'h0000_0013;

        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_pc", PC, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_instret", instret, 32'd0);

        // Release with ack tied high: the idle-cycle ack must be ignored.
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0040_0113;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("c2_req", {31'd0, imem_req}, 32'd1);
        chk("c2_addr", imem_addr, 32'd0);
        chk("c2_valid", {31'd0, instr_valid}, 32'd0);
        chk("c2_instr", Instr, 32'h0000_0013);
        tick();
        imem_ack = 1'b0;
        m_instr  = 32'h0040_0113;
        chk("c3_valid", {31'd0, instr_valid}, 32'd1);
        chk("c3_instr", Instr, m_instr);
        chk("c3_instret", instret, 32'd0);

        retire(0, 1'b1, 32'h10, h);
        fetch(3, 32'h00A0_0093);
        retire(4, 1'b1, 32'hFFFF_FFF8, h);
        chk("bwd_target", m_pc, 32'h08);
        fetch(0, 32'h0000_0033);
        retire(1, 1'b1, 32'h18, h);
        fetch(1, 32'h0000_0063);
        retire(0, 1'b0, 32'h40, h);
        chk("seq_target", imem_addr, 32'h24);
        fetch(2, 32'h0000_0003);
        retire(0, 1'b1, 32'hFFFF_FFFC, h);

        // Randomized aligned traffic, including wrap-around targets.
        for (int n = 0; n < 40; n++) begin
            fetch(int'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 7) == 0) imm = 32'hFFFF_F000 - m_pc;
            else imm = 32'($signed(int'($urandom_range(0, 63)) - 32) * 4);
            retire(int'($urandom_range(0, 2)), 1'($urandom), imm, h);
            chk("rand_nohalt", {31'd0, h}, 32'd0);
        end

        // Reset mid-request with a same-cycle ack.
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst        = 1'b1;
        #1;
        chk("mid_pc", PC, 32'd0);
        chk("mid_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_instr", Instr, 32'h0000_0013);
        chk("mid_req0", {31'd0, imem_req}, 32'd0);
        tick();
        chk("mid_instr2", Instr, 32'h0000_0013);
        chk("mid_instret", instret, 32'd0);
        rst       = 1'b0;
        imem_ack  = 1'b0;
        m_pc      = 32'd0;
        m_instret = 32'd0;
        tick();
        fetch(0, 32'h0000_0013);
        retire(0, 1'b1, 32'h20, h);
        fetch(1, 32'h0000_0063);

        // Misaligned branch target: sticky fault and terminal halt.
        retire(2, 1'b1, 32'h6, h);
        chk("halt_flag", {31'd0, h}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            stall      = 1'($urandom);
            PCSrc      = 1'($urandom);
            ImmExt     = $urandom;
            tick();
            chk("halt_fault", {31'd0, fetch_fault}, 32'd1);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_pc", PC, 32'h20);
            chk("halt_instret", instret, m_instret);
        end
        rst = 1'b1;
        #1;
        chk("clr_fault", {31'd0, fetch_fault}, 32'd0);
        chk("clr_pc", PC, 32'd0);
        tick();
        rst      = 1'b0;
        imem_ack = 1'b0;
        tick();
        chk("resume_req", {31'd0, imem_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
